// File: rtl/mux_arb_pkg.sv
// -----------------------------------------------------------------------------
// mux_arb_pkg
// Shared types and constants for the two-requester mux arbiter.
//   arb_state_t : arbiter FSM state (IDLE, GNT0, GNT1)
//   SRC0 / SRC1 : source indices; also the mux select value for each source
// -----------------------------------------------------------------------------
package mux_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  localparam logic SRC0 = 1'b0;
  localparam logic SRC1 = 1'b1;

endpackage : mux_arb_pkg

// File: rtl/mux2_w.sv
// -----------------------------------------------------------------------------
// mux2_w
// WIDTH-bit 2:1 multiplexer, purely combinational.
// Ports:
//   a   in  WIDTH  input chosen when sel = 0
//   b   in  WIDTH  input chosen when sel = 1
//   sel in  1      select
//   f   out WIDTH  sel ? b : a
// -----------------------------------------------------------------------------
module mux2_w #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] f
);

  assign f = sel ? b : a;

endmodule : mux2_w

// File: rtl/mux_arbiter.sv
// -----------------------------------------------------------------------------
// mux_arbiter
// Two-requester round-robin arbiter owning the select line of a shared 2:1
// mux. The winner is registered; its payload is steered onto out_data through
// a mux2_w instance.
//
// Optional feature macro: MUX_ARB_TIMEOUT_EN
//   When defined, a source holding the grant while the other source requests
//   is preempted after MAX_HOLD such cycles. When undefined, a grant is held
//   until its request drops and MAX_HOLD has no effect.
//
// Parameters:
//   WIDTH     data width of each source and of out_data
//   MAX_HOLD  preemption limit in cycles (>= 2), timeout build only
// Ports:
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   req0/req1  in   1      requests from source 0 / source 1
//   data0/1    in   WIDTH  source payloads
//   gnt0/gnt1  out  1      registered grants, one-hot or zero
//   sel        out  1      registered mux select (0 -> data0, 1 -> data1)
//   out_valid  out  1      gnt0 | gnt1
//   out_data   out  WIDTH  sel ? data1 : data0
// -----------------------------------------------------------------------------
module mux_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  // A MAX_HOLD below 2 would preempt on the very first waiting cycle; the
  // empty block only exists so an illegal value is easy to spot in a netlist.
  if (MAX_HOLD < 2) begin : g_max_hold_too_small
  end

  arb_state_t state_q, state_d;
  logic       gnt0_q, gnt0_d;
  logic       gnt1_q, gnt1_d;
  logic       sel_q, sel_d;
  logic       last_q, last_d;

`ifdef MUX_ARB_TIMEOUT_EN
  localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              other_req;
  logic              hold_expired;

  // The "other" request is the one waiting behind the current grant.
  always_comb begin
    other_req = 1'b0;
    case (state_q)
      GNT0:    other_req = req1;
      GNT1:    other_req = req0;
      default: other_req = 1'b0;
    endcase
  end

  assign hold_expired = other_req && (hold_cnt_q == HOLD_LAST);
`endif

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req0 && req1) begin
          // Contention: the source that was not granted last wins.
          state_d = (last_q == SRC0) ? GNT1 : GNT0;
        end else if (req0) begin
          state_d = GNT0;
        end else if (req1) begin
          state_d = GNT1;
        end
      end
      GNT0: begin
        if (!req0) begin
          // Direct handoff, no IDLE bubble, when the other side is waiting.
          state_d = req1 ? GNT1 : IDLE;
        end
`ifdef MUX_ARB_TIMEOUT_EN
        else if (hold_expired) begin
          state_d = GNT1;
        end
`endif
      end
      GNT1: begin
        if (!req1) begin
          state_d = req0 ? GNT0 : IDLE;
        end
`ifdef MUX_ARB_TIMEOUT_EN
        else if (hold_expired) begin
          state_d = GNT0;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs are derived from the next state so they line up with
  // the state register. sel and last only move on entry to a grant, so the
  // mux keeps pointing at the previous owner while idle.
  always_comb begin
    gnt0_d = (state_d == GNT0);
    gnt1_d = (state_d == GNT1);
    sel_d  = sel_q;
    last_d = last_q;
    case (state_d)
      GNT0: begin
        sel_d  = SRC0;
        last_d = SRC0;
      end
      GNT1: begin
        sel_d  = SRC1;
        last_d = SRC1;
      end
      default: ;
    endcase
  end

`ifdef MUX_ARB_TIMEOUT_EN
  // Counts cycles the other source has waited under the current grant;
  // cleared on every grant change and whenever nobody is waiting.
  always_comb begin
    hold_cnt_d = '0;
    if (state_d == state_q && other_req) begin
      hold_cnt_d = (hold_cnt_q == HOLD_LAST) ? hold_cnt_q
                                             : hold_cnt_q + HOLD_W'(1);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      sel_q      <= SRC0;
      last_q     <= SRC1;  // source 0 wins the first contention
`ifdef MUX_ARB_TIMEOUT_EN
      hold_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      sel_q      <= sel_d;
      last_q     <= last_d;
`ifdef MUX_ARB_TIMEOUT_EN
      hold_cnt_q <= hold_cnt_d;
`endif
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign sel       = sel_q;
  assign out_valid = gnt0_q | gnt1_q;

  mux2_w #(
    .WIDTH (WIDTH)
  ) u_mux (
    .a   (data0),
    .b   (data1),
    .sel (sel_q),
    .f   (out_data)
  );

endmodule : mux_arbiter

// File: tb/tb_mux_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux_arbiter
// Self-checking bench for mux_arbiter: a table of directed single-cycle
// vectors followed by hand-written multi-cycle sequences (first contention,
// round-robin alternation, hold/timeout, async reset, random invariants).
// Honours MUX_ARB_TIMEOUT_EN for the hold/timeout sequence.
// -----------------------------------------------------------------------------
module tb_mux_arbiter;

  localparam int WIDTH    = 8;
  localparam int MAX_HOLD = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0, req1;
  logic [WIDTH-1:0] data0, data1;
  logic             gnt0, gnt1, sel, out_valid;
  logic [WIDTH-1:0] out_data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mux_arbiter #(
    .WIDTH    (WIDTH),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0),
    .req1      (req1),
    .data0     (data0),
    .data1     (data1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  typedef struct {
    logic             r0, r1;
    logic [WIDTH-1:0] d0, d1;
    logic             g0, g1, s, ov;
    logic [WIDTH-1:0] od;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic g0, input logic g1,
                           input logic s, input logic ov, input logic [WIDTH-1:0] od);
    check({name, ".gnt0"},      32'(gnt0),      32'(g0));
    check({name, ".gnt1"},      32'(gnt1),      32'(g1));
    check({name, ".sel"},       32'(sel),       32'(s));
    check({name, ".out_valid"}, 32'(out_valid), 32'(ov));
    check({name, ".out_data"},  32'(out_data),  32'(od));
    $display("%s: req=%b%b gnt=%b%b sel=%b ov=%b out=%h",
             name, req0, req1, gnt0, gnt1, sel, out_valid, out_data);
  endtask

  // Advance one rising edge and settle a little after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0  = 1'b0;
    req1  = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  vec_t vecs[12];

  initial begin
    // Directed vectors: inputs applied, one edge, outputs compared.
    vecs[0]  = '{1'b1, 1'b0, 8'hA5, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5};
    vecs[1]  = '{1'b1, 1'b0, 8'hA5, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5};
    vecs[2]  = '{1'b0, 1'b0, 8'hA5, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5};
    vecs[3]  = '{1'b0, 1'b1, 8'h11, 8'h22, 1'b0, 1'b1, 1'b1, 1'b1, 8'h22};
    vecs[4]  = '{1'b0, 1'b0, 8'h11, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 8'h22};
    vecs[5]  = '{1'b1, 1'b1, 8'h33, 8'h44, 1'b1, 1'b0, 1'b0, 1'b1, 8'h33};
    vecs[6]  = '{1'b0, 1'b1, 8'h33, 8'h44, 1'b0, 1'b1, 1'b1, 1'b1, 8'h44};
    vecs[7]  = '{1'b1, 1'b1, 8'h33, 8'h44, 1'b0, 1'b1, 1'b1, 1'b1, 8'h44};
    vecs[8]  = '{1'b1, 1'b0, 8'h55, 8'h66, 1'b1, 1'b0, 1'b0, 1'b1, 8'h55};
    vecs[9]  = '{1'b0, 1'b0, 8'h55, 8'h66, 1'b0, 1'b0, 1'b0, 1'b0, 8'h55};
    vecs[10] = '{1'b1, 1'b1, 8'h77, 8'h88, 1'b0, 1'b1, 1'b1, 1'b1, 8'h88};
    vecs[11] = '{1'b0, 1'b0, 8'h77, 8'h88, 1'b0, 1'b0, 1'b1, 1'b0, 8'h88};

    rst_n = 1'b1;
    req0  = 1'b0;
    req1  = 1'b0;
    data0 = 8'hA5;
    data1 = 8'h3C;
    #2;
    rst_n = 1'b0;
    #1;
    check_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5);
    step();
    step();
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      req0  = vecs[i].r0;
      req1  = vecs[i].r1;
      data0 = vecs[i].d0;
      data1 = vecs[i].d1;
      step();
      check_all($sformatf("vec%0d", i), vecs[i].g0, vecs[i].g1, vecs[i].s,
                vecs[i].ov, vecs[i].od);
    end

    // First contention after reset goes to source 0, then direct handoff.
    do_reset();
    data0 = 8'hC3;
    data1 = 8'h5A;
    req0  = 1'b1;
    req1  = 1'b1;
    step();
    check_all("first_cont", 1'b1, 1'b0, 1'b0, 1'b1, 8'hC3);
    req0 = 1'b0;
    step();
    check_all("handoff", 1'b0, 1'b1, 1'b1, 1'b1, 8'h5A);
    req1 = 1'b0;
    step();
    check_all("handoff_rel", 1'b0, 1'b0, 1'b1, 1'b0, 8'h5A);

    // Round-robin over 8 contentions; last owner was source 1.
    begin
      logic exp_src;
      exp_src = 1'b0;
      for (int i = 0; i < 8; i++) begin
        req0 = 1'b1;
        req1 = 1'b1;
        step();
        check_all($sformatf("rr%0d", i), !exp_src, exp_src, exp_src, 1'b1,
                  exp_src ? data1 : data0);
        req0 = 1'b0;
        req1 = 1'b0;
        step();
        check_all($sformatf("rr%0d_rel", i), 1'b0, 1'b0, exp_src, 1'b0,
                  exp_src ? data1 : data0);
        exp_src = ~exp_src;
      end
    end

    // Hold / timeout: req0 granted, req1 raised the cycle after.
    req0 = 1'b1;
    step();
    check_all("hold_gnt0", 1'b1, 1'b0, 1'b0, 1'b1, data0);
    req1 = 1'b1;
`ifdef MUX_ARB_TIMEOUT_EN
    for (int k = 1; k <= MAX_HOLD; k++) begin
      step();
      if (k < MAX_HOLD)
        check_all($sformatf("tmo_wait%0d", k), 1'b1, 1'b0, 1'b0, 1'b1, data0);
      else
        check_all("tmo_preempt", 1'b0, 1'b1, 1'b1, 1'b1, data1);
    end
    req1 = 1'b0;
    step();
    check_all("tmo_regrant", 1'b1, 1'b0, 1'b0, 1'b1, data0);
`else
    for (int k = 1; k <= 20; k++) begin
      step();
      check_all($sformatf("hold%0d", k), 1'b1, 1'b0, 1'b0, 1'b1, data0);
    end
    req0 = 1'b0;
    step();
    check_all("hold_handoff", 1'b0, 1'b1, 1'b1, 1'b1, data1);
`endif
    req0 = 1'b0;
    req1 = 1'b0;
    step();

    // Asynchronous reset in the middle of a GNT1 grant.
    data0 = 8'h0F;
    data1 = 8'hF0;
    req1  = 1'b1;
    step();
    check_all("pre_rst_gnt1", 1'b0, 1'b1, 1'b1, 1'b1, 8'hF0);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 1'b0, 1'b0, 1'b0, 1'b0, 8'h0F);
    step();
    rst_n = 1'b1;
    step();
    check_all("post_rst_gnt1", 1'b0, 1'b1, 1'b1, 1'b1, 8'hF0);
    req1 = 1'b0;
    step();

    // Random requests: structural invariants every cycle.
    begin
      int bad_before;
      logic p0, p1;
      bad_before = n_bad;
      for (int c = 0; c < 1000; c++) begin
        req0  = 1'($urandom_range(0, 1));
        req1  = 1'($urandom_range(0, 1));
        data0 = 8'($urandom);
        data1 = 8'($urandom);
        p0 = req0;
        p1 = req1;
        step();
        check("rnd.overlap", 32'(gnt0 & gnt1), 32'd0);
        check("rnd.valid",   32'(out_valid),   32'(gnt0 | gnt1));
        check("rnd.data",    32'(out_data),    32'(sel ? data1 : data0));
        // A grant is only ever given to a source whose request was sampled.
        check("rnd.gnt_req", 32'((gnt0 & !p0) | (gnt1 & !p1)), 32'd0);
      end
      $display("random: 1000 cycles, %0d new mismatches", n_bad - bad_before);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_mux_arbiter
